// File: rtl/edge_arb_pkg.sv
// edge_arb_pkg: shared types, limits and round-robin search for edge_event_arbiter
package edge_arb_pkg;

    localparam int N_CH_MAX = 32;

    typedef enum logic {ARB_IDLE, ARB_OFFER} arb_state_t;

    // Returns the first set bit of mask searching upward from last+1, wrapping at n
    function automatic logic [4:0] rr_pick(
        input logic [N_CH_MAX-1:0] mask,
        input logic [4:0]          last,
        input int                  n
    );
        logic [4:0] pick;
        logic       found;
        logic [6:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_CH_MAX; k++) begin
            idx = {2'b00, last} + 7'(k);
            if (idx >= 7'(n))
                idx = idx - 7'(n);
            if (!found && k <= n && mask[idx[4:0]]) begin
                found = 1'b1;
                pick  = idx[4:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/edge_rise_det.sv
// edge_rise_det: single-line rising edge detector gated by a post-reset primed flag
module edge_rise_det (
    input  logic clk,
    input  logic reset,
    input  logic primed,
    input  logic line,
    output logic rise
);

    logic prev;

    // Track the previous line level every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            prev <= 1'b0;
        else
            prev <= line;
    end

    assign rise = primed & line & ~prev;

endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel rising-edge pending flags served round-robin on one valid/ready port
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int ID_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] in_lines,
    input  logic [N_CH-1:0] en_mask,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_id,
    output logic [N_CH-1:0] pending,
    output logic [N_CH-1:0] overflow,
    input  logic [N_CH-1:0] ovf_clr
);

    arb_state_t      state, state_d;
    logic            primed;
    logic            hs;
    logic [N_CH-1:0] rise, hit, hs_vec;
    logic [ID_W-1:0] id_d, last_grant, lg_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_det
        edge_rise_det u_det (
            .clk    (clk),
            .reset  (reset),
            .primed (primed),
            .line   (in_lines[i]),
            .rise   (rise[i])
        );
    end

    assign evt_valid = (state == ARB_OFFER);
    assign hs        = evt_valid & evt_ready;
    assign hs_vec    = hs ? (N_CH'(1) << evt_id) : '0;
    assign hit       = rise & en_mask;

    // Suppress edges on the first cycle after reset so lines already high stay silent
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            primed <= 1'b0;
        else
            primed <= 1'b1;
    end

    // A new edge beats a same-cycle handshake clear; an edge on an unserved pending flag is lost
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= hit | (pending & ~hs_vec);
            overflow <= (overflow & ~ovf_clr) | (hit & pending & ~hs_vec);
        end
    end

    // Arbiter state, offered index and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            evt_id     <= '0;
            last_grant <= ID_W'(N_CH - 1);
        end else begin
            state      <= state_d;
            evt_id     <= id_d;
            last_grant <= lg_d;
        end
    end

    // Pick from registered pending in IDLE; hold the offer until handshake
    always_comb begin
        state_d = state;
        id_d    = evt_id;
        lg_d    = last_grant;
        if (state == ARB_IDLE) begin
            if (|pending) begin
                state_d = ARB_OFFER;
                id_d    = ID_W'(rr_pick(N_CH_MAX'(pending), 5'(last_grant), N_CH));
            end
        end else if (evt_ready) begin
            state_d = ARB_IDLE;
            lg_d    = evt_id;
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: table-driven directed check of edge_event_arbiter
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_lines, en_mask, ovf_clr;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [3:0] pending, overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rn;
        logic [3:0] lines;
        logic [3:0] en;
        logic       rdy;
        logic [3:0] clr;
        logic       v;
        logic [1:0] id;
        logic [3:0] p;
        logic [3:0] o;
    } vec_t;

    vec_t vecs[$];

    edge_event_arbiter #(.N_CH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_lines  (in_lines),
        .en_mask   (en_mask),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .pending   (pending),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rn, input logic [3:0] lines, input logic [3:0] en, input logic rdy,
                       input logic [3:0] clr, input logic v, input logic [1:0] id,
                       input logic [3:0] p, input logic [3:0] o);
        vec_t t;
        t.rn = rn; t.lines = lines; t.en = en; t.rdy = rdy; t.clr = clr;
        t.v = v; t.id = id; t.p = p; t.o = o;
        vecs.push_back(t);
    endtask

    initial begin
        reset     = 1'b0;
        in_lines  = 4'b0011;
        en_mask   = 4'b1111;
        evt_ready = 1'b0;
        ovf_clr   = 4'b0000;
        step();
        step();
        chk("rst_valid",    32'(evt_valid), 32'd0);
        chk("rst_id",       32'(evt_id),    32'd0);
        chk("rst_pending",  32'(pending),   32'd0);
        chk("rst_overflow", 32'(overflow),  32'd0);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("steady_valid",   32'(evt_valid), 32'd0);
            chk("steady_pending", 32'(pending),   32'd0);
        end

        // rn lines  en     rdy clr     v  id p       o
        add(1, 4'b0111, 4'b1111, 0, 4'b0000, 0, 0, 4'b0100, 4'b0000);
        add(1, 4'b0111, 4'b1111, 1, 4'b0000, 1, 2, 4'b0100, 4'b0000);
        add(1, 4'b0111, 4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(1, 4'b0000, 4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(0, 4'b0000, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(1, 4'b0000, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 4'b1111, 4'b0000);
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 1, 0, 4'b1111, 4'b0000);
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 4'b1110, 4'b0000);
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 1, 1, 4'b1110, 4'b0000);
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 4'b1100, 4'b0000);
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 1, 2, 4'b1100, 4'b0000);
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 4'b1000, 4'b0000);
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 1, 3, 4'b1000, 4'b0000);
        add(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(1, 4'b0000, 4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(1, 4'b1001, 4'b1111, 1, 4'b0000, 0, 0, 4'b1001, 4'b0000);
        add(1, 4'b1001, 4'b1111, 1, 4'b0000, 1, 0, 4'b1001, 4'b0000);
        add(1, 4'b1001, 4'b1111, 1, 4'b0000, 0, 0, 4'b1000, 4'b0000);
        add(1, 4'b1001, 4'b1111, 1, 4'b0000, 1, 3, 4'b1000, 4'b0000);
        add(1, 4'b1001, 4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(1, 4'b0000, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(1, 4'b0010, 4'b1111, 0, 4'b0000, 0, 0, 4'b0010, 4'b0000);
        add(1, 4'b0010, 4'b1111, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000);
        add(1, 4'b0000, 4'b1111, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000);
        add(1, 4'b0010, 4'b1111, 0, 4'b0000, 1, 1, 4'b0010, 4'b0010);
        add(1, 4'b0010, 4'b1111, 0, 4'b0000, 1, 1, 4'b0010, 4'b0010);
        add(1, 4'b0010, 4'b1111, 0, 4'b0000, 1, 1, 4'b0010, 4'b0010);
        add(1, 4'b0010, 4'b1111, 0, 4'b0000, 1, 1, 4'b0010, 4'b0010);
        add(1, 4'b0010, 4'b1111, 0, 4'b0010, 1, 1, 4'b0010, 4'b0000);
        add(1, 4'b0010, 4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(1, 4'b0000, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(1, 4'b0010, 4'b1111, 0, 4'b0000, 0, 0, 4'b0010, 4'b0000);
        add(1, 4'b0000, 4'b1111, 0, 4'b0000, 1, 1, 4'b0010, 4'b0000);
        add(1, 4'b0010, 4'b1111, 1, 4'b0000, 0, 0, 4'b0010, 4'b0000);
        add(1, 4'b0010, 4'b1111, 1, 4'b0000, 1, 1, 4'b0010, 4'b0000);
        add(1, 4'b0010, 4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(1, 4'b0000, 4'b1110, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(1, 4'b0001, 4'b1110, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(1, 4'b0001, 4'b1110, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);

        foreach (vecs[n]) begin
            reset     = vecs[n].rn;
            in_lines  = vecs[n].lines;
            en_mask   = vecs[n].en;
            evt_ready = vecs[n].rdy;
            ovf_clr   = vecs[n].clr;
            step();
            chk($sformatf("v%0d_valid", n),    32'(evt_valid), 32'(vecs[n].v));
            if (vecs[n].v)
                chk($sformatf("v%0d_id", n),   32'(evt_id),    32'(vecs[n].id));
            chk($sformatf("v%0d_pending", n),  32'(pending),   32'(vecs[n].p));
            chk($sformatf("v%0d_overflow", n), 32'(overflow),  32'(vecs[n].o));
        end

        en_mask   = 4'b1111;
        evt_ready = 1'b0;
        ovf_clr   = 4'b0000;
        in_lines  = 4'b0101;
        step();
        chk("mo_pending", 32'(pending), 32'b0100);
        step();
        chk("mo_valid", 32'(evt_valid), 32'd1);
        chk("mo_id",    32'(evt_id),    32'd2);
        in_lines = 4'b0001;
        step();
        in_lines = 4'b0101;
        step();
        chk("mo_overflow", 32'(overflow), 32'b0100);
        en_mask = 4'b0000;
        step();
        chk("mask_keep_pending", 32'(pending),   32'b0100);
        chk("mask_keep_valid",   32'(evt_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid",    32'(evt_valid), 32'd0);
        chk("async_pending",  32'(pending),   32'd0);
        chk("async_overflow", 32'(overflow),  32'd0);
        step();
        reset = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
